uart_byte_rx: RTL

Receive half of the team's RS-232 UART: recovers 8N1 bytes from the serial line `rs232_Rx` using 16x oversampling with 3-sample majority voting, and presents each byte on a parallel bus with a one-cycle `rx_done` strobe. It pairs with the byte transmitter, using the same `baud_set` encoding and a 50 MHz `clk`. It sits between the board pin and the byte-level consumer, such as a loopback path or a command parser.

---
 rtl/uart_byte_rx_if.sv | 28 ++
 rtl/uart_byte_rx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial-in / byte-out bundle for the UART receiver.
// slave = receiver side; master = line driver and byte consumer side.
interface uart_byte_rx_if;
  logic [2:0] baud_set;
  logic       rs232_Rx;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  modport slave (
    input  baud_set,
    input  rs232_Rx,
    output data_byte,
    output rx_done,
    output frame_err,
    output uart_state
  );

  modport master (
    output baud_set,
    output rs232_Rx,
    input  data_byte,
    input  rx_done,
    input  frame_err,
    input  uart_state
  );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver, 16x oversampling, 3-sample majority vote.
// Ports: clk, rst (sync, active-high), bus (slave): baud_set, rs232_Rx in;
// data_byte, rx_done, frame_err, uart_state out.
module uart_byte_rx #(
  parameter logic SYNC_INIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  uart_byte_rx_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  state_t state_nx;

  logic       s1;
  logic       rx_s;
  logic       rx_d;
  logic [8:0] sub_dr;
  logic [8:0] div_cnt;
  logic [7:0] idx;
  logic [1:0] smp;
  logic [7:0] shreg;
  logic [7:0] data_q;
  logic       done_q;
  logic       err_q;

  logic       start_edge;
  logic       tick;
  logic       mid;
  logic       capture;
  logic       vote;
  logic [3:0] bit_no;
  logic       load;
  logic       shift_en;
  logic       stop_ok;
  logic       stop_bad;

  function automatic logic [8:0] dr_of(input logic [2:0] b);
    logic [8:0] r;
    case (b)
      3'b000:  r = 9'd324;
      3'b001:  r = 9'd162;
      3'b010:  r = 9'd80;
      3'b011:  r = 9'd53;
      3'b100:  r = 9'd26;
      default: r = 9'd324;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= SYNC_INIT;
      rx_s <= SYNC_INIT;
      rx_d <= SYNC_INIT;
    end else begin
      s1   <= bus.rs232_Rx;
      rx_s <= s1;
      rx_d <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;
  assign tick       = (div_cnt == sub_dr);
  assign bit_no     = idx[7:4];

  // third vote sample is taken live on the decision tick
  assign mid = (state == BUSY) && tick
            && (idx[3:0] == 4'd8);
  assign capture = (state == BUSY) && tick
            && (idx[3:0] == 4'd6 || idx[3:0] == 4'd7);
  assign vote = (smp[1] & smp[0])
              | (smp[1] & rx_s)
              | (smp[0] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nx = BUSY;
          load     = 1'b1;
        end
      end
      BUSY: begin
        if (mid) begin
          if (bit_no == 4'd0) begin
            // start bit voted high: glitch
            if (vote) state_nx = IDLE;
          end else if (bit_no == 4'd9) begin
            state_nx = IDLE;
            stop_ok  = vote;
            stop_bad = ~vote;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_dr  <= 9'd324;
      div_cnt <= '0;
      idx     <= '0;
      smp     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= stop_ok;
      err_q  <= stop_bad;
      if (load) begin
        sub_dr  <= dr_of(bus.baud_set);
        div_cnt <= '0;
        idx     <= '0;
      end else if (state == BUSY) begin
        if (tick) begin
          div_cnt <= '0;
          idx     <= idx + 8'd1;
        end else begin
          div_cnt <= div_cnt + 9'd1;
        end
      end
      if (capture) smp <= {smp[0], rx_s};
      if (shift_en) shreg <= {vote, shreg[7:1]};
      if (stop_ok) data_q <= shreg;
    end
  end

  assign bus.data_byte  = data_q;
  assign bus.rx_done    = done_q;
  assign bus.frame_err  = err_q;
  assign bus.uart_state = (state == BUSY);

endmodule
